bf_pair_feeder: RTL and testbench
=================================

# bf_pair_feeder

Input commutator for one R2MDC FFT stage. It takes a serial stream of complex Q8.8 samples and delays the first half of each N-point frame. It then presents each buffered sample alongside its partner from the second half, together with the matching twiddle factor, as one butterfly operand set (A, B, W). It sits directly upstream of `bf_radix2`, which consumes A_re/A_im, B_re/B_im and W_re/W_im. It produces exactly the operand pairing that `bf_radix2` expects: Y0 = A+B, Y1 = (A−B)·W.

## Interface
Parameters:
- `DW`, 16: sample and twiddle word width, signed Q8.8.
- `LOG2N`, 4: log2 of the frame length N. Legal range 1..4.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  input sample present this cycle.
- `in_sof`  in  1  qualified by `in_valid`; this sample is index 0 of a new frame.
- `in_re`, `in_im`  in  DW  input sample, signed Q8.8.
- `out_valid`  out  1  operand set valid this cycle.
- `out_eof`  out  1  with `out_valid`; last pair of the frame.
- `A_re`, `A_im`  out  DW  buffered first-half sample x[k].
- `B_re`, `B_im`  out  DW  second-half sample x[k+N/2].
- `W_re`, `W_im`  out  DW  twiddle W_N^k, Q8.8.
- `tw_idx`  out  LOG2N-1  twiddle index k (0..N/2−1).
- `sof_err`  out  1  one-cycle pulse when a frame is restarted before completion.

## Operation
- Sample counter `cnt` runs 0..N−1 and advances only on `in_valid`. An N/2-deep buffer holds the first-half samples (registers or distributed RAM).
- FILL state (`cnt` < N/2): write `{in_re,in_im}` to `buf[cnt]`. No output.
- PAIR state (`cnt` ≥ N/2): with k = `cnt` − N/2, register the following:
  - A = buf[k];
  - B = in;
  - W = tw(k);
  - `tw_idx` = k;
  - `out_valid` = 1.
  - `out_eof` = 1 when k = N/2−1.
- After `cnt` = N−1, `cnt` wraps to 0 and the block returns to FILL.
- `in_valid` = 0: all state holds and `out_valid` = 0 next cycle. Output data registers hold their last values.
- `in_sof` with `in_valid`: the sample is treated as index 0 and written to `buf[0]`, and `cnt` becomes 1. If `cnt` ≠ 0 at that point, `sof_err` pulses next cycle, the partial frame is discarded, and no pair is emitted for the abandoned frame. `in_sof` when `cnt` = 0 is normal.
- Data passes through unmodified: no arithmetic, rounding or saturation. The twiddle is W_N^k = cos(2πk/N) − j·sin(2πk/N), scaled by 256 and rounded to nearest.

## Timing
- Latency is 1 cycle from the in_valid cycle of sample N/2+k to `out_valid` for pair k.
- Throughput is 1 sample per cycle. The output is bursty: N/2 idle cycles then N/2 valid cycles per frame at a full input rate. There is no backpressure, so the downstream block must accept every `out_valid` cycle.
- `buf` write and read of the same index never coincide within one frame. An `in_sof` restart overwrites `buf[0]` while no read is pending.
- Reset (`rst_n` = 0 at a rising edge, including mid-frame) forces the following:
  - `cnt` = 0 and state FILL;
  - `out_valid`, `out_eof`, `sof_err` = 0;
  - all data outputs = 0 and `tw_idx` = 0.
  - Buffer contents need not be cleared; they are never read before being rewritten.
- `out_eof` is asserted only together with `out_valid`.

## Configuration
- `BF_FEEDER_TWIDDLE_ROM_EN` defined:
  - An internal 8-entry Q8.8 ROM for W_16^k is compiled in.
  - The ROM is addressed with k·(16/N), so every legal LOG2N is served from this one table.
  - Entries k = 0..7: (256,0), (237,−98), (181,−181), (98,−237), (0,−256), (−98,−237), (−181,−181), (−237,−98).
  - `W_re`/`W_im` carry the ROM value, registered alongside A and B.
- Macro undefined:
  - No ROM. `W_re` = 256 and `W_im` = 0 at all times once out of reset; both are 0 during reset.
  - `tw_idx` alone identifies the twiddle, and the stage wrapper supplies W from `tw_idx`.

## Test plan
- Reset, then N=16 with in_re = 0..15 (each ×256) and in_im = 0, sent with `in_sof` on the first sample and valid every cycle. `out_valid` pulses for 8 cycles starting on the cycle after the 9th sample. Pair k gives A_re = 256·k and B_re = 256·(k+8). `out_eof` is set on k = 7 only.
- With ROM enabled in the same run, pair k=2 gives W = (181,−181) and pair k=4 gives W = (0,−256). With ROM disabled, every pair gives W = (256,0) and `tw_idx` = 0..7.
- Drop `in_valid` low for 3 cycles between samples 10 and 11. `out_valid` drops for exactly those 3 cycles, and pair 3 then still carries A_re = 768, B_re = 2816.
- Assert `in_sof` on sample 5 of a frame. `sof_err` pulses once and no pairs are emitted for the old frame. A full new frame then yields 8 correct pairs.
- Assert `rst_n` = 0 for one cycle at pair k = 3. All outputs are 0 the next cycle, and the following 8 samples produce no `out_valid`.
- LOG2N = 2 with ROM enabled, sending samples (256,25), (256,−1171), (256,0), (512,0). Pair 0 gives A = (256,25), B = (256,0), W = (256,0). Pair 1 gives A = (256,−1171), B = (512,0), W = (0,−256).

Source files
------------

// File: rtl/bf_pair_feeder.sv
// R2MDC stage input commutator: buffers the first half of each frame and pairs it with the second half.
// Optional BF_FEEDER_TWIDDLE_ROM_EN compiles in an 8-entry W_16 twiddle ROM; otherwise W is fixed at (256,0).
module bf_pair_feeder #(
   parameter  int DW    = 16,
   parameter  int LOG2N = 4,
   localparam int KW    = (LOG2N > 1) ? LOG2N - 1 : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic          in_sof,
   input  logic [DW-1:0] in_re,
   input  logic [DW-1:0] in_im,
   output logic          out_valid,
   output logic          out_eof,
   output logic [DW-1:0] A_re,
   output logic [DW-1:0] A_im,
   output logic [DW-1:0] B_re,
   output logic [DW-1:0] B_im,
   output logic [DW-1:0] W_re,
   output logic [DW-1:0] W_im,
   output logic [KW-1:0] tw_idx,
   output logic          sof_err
);

   //  state  | meaning
   //  S_FILL | cnt < N/2, first-half sample written to buffer, no output
   //  S_PAIR | cnt >= N/2, buffered x[k] paired with incoming x[k+N/2]
   typedef enum logic {S_FILL, S_PAIR} state_t;

   localparam int N    = 1 << LOG2N;
   localparam int HALF = N / 2;

   state_t             r_state;
   logic [LOG2N-1:0]   r_cnt;
   logic [2*DW-1:0]    r_buf [HALF];

   logic [KW-1:0]      w_k;
   logic [LOG2N-1:0]   w_cnt_inc;
   logic               w_last;
   logic [2*DW-1:0]    w_rd;

   // The low bits of cnt are the buffer index in FILL and equal k in PAIR.
   generate
      if (LOG2N > 1) begin : g_k
         assign w_k = r_cnt[KW-1:0];
      end else begin : g_k1
         assign w_k = '0;
      end
   endgenerate

   assign w_cnt_inc = r_cnt + LOG2N'(1);
   assign w_last    = (w_k == KW'(HALF - 1));
   assign w_rd      = r_buf[w_k];

`ifdef BF_FEEDER_TWIDDLE_ROM_EN
   logic [2:0]    w_rom_addr;
   logic [DW-1:0] w_rom_re;
   logic [DW-1:0] w_rom_im;

   assign w_rom_addr = 3'(w_k) << (4 - LOG2N);

   always_comb begin
      w_rom_re = DW'(256);
      w_rom_im = '0;
      case (w_rom_addr)
         3'd0: begin w_rom_re = DW'(256);  w_rom_im = DW'(0);    end
         3'd1: begin w_rom_re = DW'(237);  w_rom_im = DW'(-98);  end
         3'd2: begin w_rom_re = DW'(181);  w_rom_im = DW'(-181); end
         3'd3: begin w_rom_re = DW'(98);   w_rom_im = DW'(-237); end
         3'd4: begin w_rom_re = DW'(0);    w_rom_im = DW'(-256); end
         3'd5: begin w_rom_re = DW'(-98);  w_rom_im = DW'(-237); end
         3'd6: begin w_rom_re = DW'(-181); w_rom_im = DW'(-181); end
         3'd7: begin w_rom_re = DW'(-237); w_rom_im = DW'(-98);  end
         default: begin w_rom_re = DW'(256); w_rom_im = '0; end
      endcase
   end
`endif

   // Buffer is never read before being rewritten, so it carries no reset.
   always_ff @(posedge clk) begin
      if (in_valid) begin
         if (in_sof)
            r_buf[0] <= {in_re, in_im};
         else if (r_state == S_FILL)
            r_buf[w_k] <= {in_re, in_im};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_FILL;
         r_cnt     <= '0;
         out_valid <= 1'b0;
         out_eof   <= 1'b0;
         sof_err   <= 1'b0;
         A_re      <= '0;
         A_im      <= '0;
         B_re      <= '0;
         B_im      <= '0;
         W_re      <= '0;
         W_im      <= '0;
         tw_idx    <= '0;
      end else begin
         out_valid <= 1'b0;
         out_eof   <= 1'b0;
         sof_err   <= 1'b0;
`ifndef BF_FEEDER_TWIDDLE_ROM_EN
         W_re      <= DW'(256);
         W_im      <= '0;
`endif
         if (in_valid) begin
            if (in_sof) begin
               sof_err <= (r_cnt != '0);
               r_cnt   <= LOG2N'(1);
               r_state <= (LOG2N == 1) ? S_PAIR : S_FILL;
            end else begin
               r_cnt   <= w_cnt_inc;
               r_state <= w_cnt_inc[LOG2N-1] ? S_PAIR : S_FILL;
               if (r_state == S_PAIR) begin
                  A_re      <= w_rd[2*DW-1:DW];
                  A_im      <= w_rd[DW-1:0];
                  B_re      <= in_re;
                  B_im      <= in_im;
                  tw_idx    <= w_k;
                  out_valid <= 1'b1;
                  out_eof   <= w_last;
`ifdef BF_FEEDER_TWIDDLE_ROM_EN
                  W_re      <= w_rom_re;
                  W_im      <= w_rom_im;
`endif
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_bf_pair_feeder.sv
// Directed bench for bf_pair_feeder: N=16 instance with a scoreboard, plus an N=4 instance.
// Expected twiddles follow BF_FEEDER_TWIDDLE_ROM_EN when it is defined for the build.
module tb_bf_pair_feeder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_sof;
   logic [15:0] in_re, in_im;
   logic        out_valid, out_eof, sof_err;
   logic [15:0] A_re, A_im, B_re, B_im, W_re, W_im;
   logic [2:0]  tw_idx;

   logic        v4, s4;
   logic [15:0] re4, im4;
   logic        ov4, oe4, se4;
   logic [15:0] ar4, ai4, br4, bi4, wr4, wi4;
   logic [0:0]  ti4;

   always #5 clk = ~clk;

   bf_pair_feeder #(.DW(16), .LOG2N(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
      .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_eof(out_eof),
      .A_re(A_re), .A_im(A_im), .B_re(B_re), .B_im(B_im),
      .W_re(W_re), .W_im(W_im), .tw_idx(tw_idx), .sof_err(sof_err));

   bf_pair_feeder #(.DW(16), .LOG2N(2)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_sof(s4),
      .in_re(re4), .in_im(im4), .out_valid(ov4), .out_eof(oe4),
      .A_re(ar4), .A_im(ai4), .B_re(br4), .B_im(bi4),
      .W_re(wr4), .W_im(wi4), .tw_idx(ti4), .sof_err(se4));

   typedef struct {
      logic [15:0] are, aim, bre, bim, wre, wim;
      logic [2:0]  idx;
      logic        eof;
   } exp_t;

   exp_t        q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_valid = 0;
   int          m_cnt   = 0;
   logic [15:0] m_re [8];
   logic [15:0] m_im [8];
   logic        pend_err = 1'b0;

   function automatic logic [15:0] tw_re(input int k);
`ifdef BF_FEEDER_TWIDDLE_ROM_EN
      int t [8] = '{256, 237, 181, 98, 0, -98, -181, -237};
      return 16'(t[k]);
`else
      return 16'(256 + 0 * k);
`endif
   endfunction

   function automatic logic [15:0] tw_im(input int k);
`ifdef BF_FEEDER_TWIDDLE_ROM_EN
      int t [8] = '{0, -98, -181, -237, -256, -237, -181, -98};
      return 16'(t[k]);
`else
      return 16'(0 * k);
`endif
   endfunction

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check16();
      exp_t e;
      cmp("out_valid", 32'(out_valid), 32'(q.size() != 0));
      cmp("sof_err", 32'(sof_err), 32'(pend_err));
      if (q.size() != 0) begin
         e = q.pop_front();
         n_valid++;
         cmp("A_re", 32'(A_re), 32'(e.are));
         cmp("A_im", 32'(A_im), 32'(e.aim));
         cmp("B_re", 32'(B_re), 32'(e.bre));
         cmp("B_im", 32'(B_im), 32'(e.bim));
         cmp("W_re", 32'(W_re), 32'(e.wre));
         cmp("W_im", 32'(W_im), 32'(e.wim));
         cmp("tw_idx", 32'(tw_idx), 32'(e.idx));
         cmp("out_eof", 32'(out_eof), 32'(e.eof));
      end else begin
         cmp("out_eof_idle", 32'(out_eof), 32'd0);
      end
   endtask

   task automatic chk_zero();
      cmp("rst_valid", 32'(out_valid), 32'd0);
      cmp("rst_eof", 32'(out_eof), 32'd0);
      cmp("rst_err", 32'(sof_err), 32'd0);
      cmp("rst_A", {A_re, A_im}, 32'd0);
      cmp("rst_B", {B_re, B_im}, 32'd0);
      cmp("rst_W", {W_re, W_im}, 32'd0);
      cmp("rst_idx", 32'(tw_idx), 32'd0);
   endtask

   task automatic idle16();
      in_valid = 1'b0;
      in_sof   = 1'b0;
      pend_err = 1'b0;
      @(posedge clk); #1;
      check16();
   endtask

   task automatic send16(input logic [15:0] re, input logic [15:0] im, input logic sof);
      exp_t e;
      in_valid = 1'b1;
      in_sof   = sof;
      in_re    = re;
      in_im    = im;
      pend_err = 1'b0;
      if (sof) begin
         pend_err = (m_cnt != 0);
         m_re[0]  = re;
         m_im[0]  = im;
         m_cnt    = 1;
      end else if (m_cnt < 8) begin
         m_re[m_cnt] = re;
         m_im[m_cnt] = im;
         m_cnt++;
      end else begin
         e.are = m_re[m_cnt-8];
         e.aim = m_im[m_cnt-8];
         e.bre = re;
         e.bim = im;
         e.wre = tw_re(m_cnt - 8);
         e.wim = tw_im(m_cnt - 8);
         e.idx = 3'(m_cnt - 8);
         e.eof = (m_cnt == 15);
         q.push_back(e);
         m_cnt = (m_cnt + 1) % 16;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      check16();
   endtask

   task automatic send4(input logic [15:0] re, input logic [15:0] im, input logic sof);
      v4  = 1'b1;
      s4  = sof;
      re4 = re;
      im4 = im;
      @(posedge clk); #1;
      v4 = 1'b0;
      s4 = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_re = '0; in_im = '0;
      v4 = 1'b0; s4 = 1'b0; re4 = '0; im4 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero();
      rst_n = 1'b1;
      idle16();
`ifndef BF_FEEDER_TWIDDLE_ROM_EN
      cmp("W_out_of_reset", {W_re, W_im}, {16'd256, 16'd0});
`endif

      // Frame 1: ramp, full rate
      n_valid = 0;
      for (int i = 0; i < 16; i++) send16(16'(256 * i), 16'd0, i == 0);
      idle16();
      cmp("frame1_pairs", 32'(n_valid), 32'd8);

      // Frame 2: 3-cycle gap between samples 10 and 11
      n_valid = 0;
      for (int i = 0; i < 16; i++) begin
         send16(16'(256 * i), 16'(-100 * i), i == 0);
         if (i == 10) repeat (3) idle16();
      end
      cmp("frame2_pairs", 32'(n_valid), 32'd8);

      // Frame 3: restart at sample 5, then a full random frame
      n_valid = 0;
      for (int i = 0; i < 5; i++) send16(16'(1000 + i), 16'(i), i == 0);
      for (int i = 0; i < 16; i++) send16(16'($urandom), 16'($urandom), i == 0);
      idle16();
      cmp("frame3_pairs", 32'(n_valid), 32'd8);

      // Frame 4: reset at pair k=3
      for (int i = 0; i < 11; i++) send16(16'(256 * i), 16'(7 * i), i == 0);
      rst_n = 1'b0; in_valid = 1'b1; in_re = 16'h0b00; in_im = 16'h0001;
      @(posedge clk); #1;
      rst_n = 1'b1; in_valid = 1'b0;
      chk_zero();
      m_cnt = 0;
      q.delete();
      n_valid = 0;
      for (int i = 0; i < 8; i++) send16(16'(300 + i), 16'(-i), 1'b0);
      cmp("post_reset_fill_pairs", 32'(n_valid), 32'd0);
      for (int i = 8; i < 16; i++) send16(16'(300 + i), 16'(-i), 1'b0);
      cmp("post_reset_pairs", 32'(n_valid), 32'd8);

      // N=4 instance
      send4(16'd256, 16'd25, 1'b1);
      cmp("n4_fill_valid", 32'(ov4), 32'd0);
      send4(16'd256, 16'(-1171), 1'b0);
      cmp("n4_fill_valid2", 32'(ov4), 32'd0);
      send4(16'd256, 16'd0, 1'b0);
      cmp("n4_p0_valid", 32'(ov4), 32'd1);
      cmp("n4_p0_A", {ar4, ai4}, {16'd256, 16'd25});
      cmp("n4_p0_B", {br4, bi4}, {16'd256, 16'd0});
      cmp("n4_p0_W", {wr4, wi4}, {16'd256, 16'd0});
      cmp("n4_p0_idx_eof", {30'd0, ti4, oe4}, 32'b00);
      send4(16'd512, 16'd0, 1'b0);
      cmp("n4_p1_valid", 32'(ov4), 32'd1);
      cmp("n4_p1_A", {ar4, ai4}, {16'd256, 16'(-1171)});
      cmp("n4_p1_B", {br4, bi4}, {16'd512, 16'd0});
`ifdef BF_FEEDER_TWIDDLE_ROM_EN
      cmp("n4_p1_W", {wr4, wi4}, {16'd0, 16'(-256)});
`else
      cmp("n4_p1_W", {wr4, wi4}, {16'd256, 16'd0});
`endif
      cmp("n4_p1_idx_eof", {30'd0, ti4, oe4}, 32'b11);
      cmp("n4_sof_err", 32'(se4), 32'd0);
      @(posedge clk); #1;
      cmp("n4_idle_valid", 32'(ov4), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
